// File: rtl/dsp_tapline.sv
// -----------------------------------------------------------------------------
// dsp_tapline -- circular tap-delay line with single-tap reads and an optional
// sequential "sum of the newest N taps" engine.
//
// Configuration macro: DSP_TAPLINE_SUM_EN
//   defined   -> IDLE/SUM/DONE sum engine is built in
//   undefined -> start/nsum are ignored; busy, sum_out, sum_valid, dbg_state = 0
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en              global enable; low freezes all state, pulses drop to 0
//   we, din         sample write strobe and data
//   rd_req, rd_idx  tap read (0 = newest); answered one cycle later on dout
//   start, nsum     begin summing the newest min(nsum, level) taps
//   dout            tap read data (held between reads)
//   dout_valid      one-cycle pulse, dout updated
//   rd_err          one-cycle pulse, requested tap not yet filled (dout = 0)
//   level, full     number of stored samples, level == DEPTH
//   busy            sum engine in SUM or DONE; we/rd_req/start ignored
//   sum_out         unsigned tap sum, sum_valid one-cycle pulse when updated
//   dbg_state       sum engine state (0 IDLE, 1 SUM, 2 DONE) for checkers
//
// Handshake: a request (we, rd_req, start) is taken on any rising edge where
// en is high and the engine is idle; there is no back-pressure, a request that
// is not taken is simply dropped. A start taken on an edge blocks a write or
// read presented on that same edge.
// -----------------------------------------------------------------------------
module dsp_tapline #(
    parameter logic RST_VAL   = 1'b0,
    parameter int   BUS_WIDTH = 24,
    parameter int   DEPTH     = 8,
    parameter int   IDX_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     we,
    input  logic [BUS_WIDTH-1:0]     din,
    input  logic                     rd_req,
    input  logic [IDX_W-1:0]         rd_idx,
    input  logic                     start,
    input  logic [IDX_W:0]           nsum,
    output logic [BUS_WIDTH-1:0]     dout,
    output logic                     dout_valid,
    output logic                     rd_err,
    output logic [IDX_W:0]           level,
    output logic                     full,
    output logic                     busy,
    output logic [BUS_WIDTH+IDX_W:0] sum_out,
    output logic                     sum_valid,
    output logic [1:0]               dbg_state
);

    localparam int             SUM_W   = BUS_WIDTH + IDX_W + 1;
    localparam logic [IDX_W:0] LVL_MAX = (IDX_W+1)'(DEPTH);

    logic [BUS_WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]     r_wp;
    logic [IDX_W:0]       r_level;
    logic [BUS_WIDTH-1:0] r_dout;
    logic                 r_dout_valid;
    logic                 r_rd_err;

    logic                 w_busy;
    logic                 w_start_acc;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_rd_miss;
    logic [IDX_W-1:0]     w_rd_addr;

    assign w_wr_acc  = we && en && !w_busy && !w_start_acc;
    assign w_rd_acc  = rd_req && en && !w_busy && !w_start_acc;
    // Tap k lives at wp-1-k; DEPTH is a power of two so the wrap is free.
    assign w_rd_addr = r_wp - IDX_W'(1) - rd_idx;
    assign w_rd_miss = ({1'b0, rd_idx} >= r_level);

    // Storage, write pointer and fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i[IDX_W-1:0]] <= {BUS_WIDTH{RST_VAL}};
            end
            r_wp    <= '0;
            r_level <= '0;
        end else if (w_wr_acc) begin
            r_mem[r_wp] <= din;
            r_wp        <= r_wp + IDX_W'(1);
            // Once full, the oldest sample is overwritten and level saturates.
            if (r_level != LVL_MAX) begin
                r_level <= r_level + (IDX_W+1)'(1);
            end
        end
    end

    // Tap read port; uses pre-write memory and level when a write shares the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_rd_err     <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_acc;
            r_rd_err     <= w_rd_acc && w_rd_miss;
            if (w_rd_acc) begin
                r_dout <= w_rd_miss ? '0 : r_mem[w_rd_addr];
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign rd_err     = r_rd_err;
    assign level      = r_level;
    assign full       = (r_level == LVL_MAX);

`ifdef DSP_TAPLINE_SUM_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUM  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W:0]   w_n;
    logic [IDX_W:0]   r_cnt;     // taps still to add
    logic [IDX_W-1:0] r_ptr;     // address of the next tap to add
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] w_acc_next;
    logic [SUM_W-1:0] r_sum_out;
    logic             r_sum_valid;

    assign w_n         = (nsum < r_level) ? nsum : r_level;
    assign w_start_acc = start && en && (r_state == S_IDLE);
    assign w_acc_next  = r_acc + {{(IDX_W+1){1'b0}}, r_mem[r_ptr]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_next = (w_n == '0) ? S_DONE : S_SUM;
                end
            end
            S_SUM: begin
                w_busy = 1'b1;
                if (en && (r_cnt == (IDX_W+1)'(1))) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy = 1'b1;
                if (en) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Accumulator datapath. sum_out/sum_valid are loaded on the edge that
    // enters DONE, so the pulse coincides with the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_acc       <= '0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (w_start_acc) begin
                r_cnt <= w_n;
                r_ptr <= r_wp - IDX_W'(1);
                r_acc <= '0;
                if (w_n == '0) begin
                    r_sum_out   <= '0;
                    r_sum_valid <= 1'b1;
                end
            end else if ((r_state == S_SUM) && en) begin
                r_acc <= w_acc_next;
                r_ptr <= r_ptr - IDX_W'(1);
                r_cnt <= r_cnt - (IDX_W+1)'(1);
                if (r_cnt == (IDX_W+1)'(1)) begin
                    r_sum_out   <= w_acc_next;
                    r_sum_valid <= 1'b1;
                end
            end
        end
    end

    assign busy      = w_busy;
    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign dbg_state = r_state;
`else
    logic w_unused_sum_in;

    assign w_unused_sum_in = ^{start, nsum};
    assign w_start_acc     = 1'b0;
    assign w_busy          = 1'b0;
    assign busy            = 1'b0;
    assign sum_out         = '0;
    assign sum_valid       = 1'b0;
    assign dbg_state       = 2'd0;
`endif

endmodule
